// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: word RAM with byte-lane writes, programmable
// response latency and out-of-range detection, answering the core's dmem requests.
module dmem_responder #(
  parameter int unsigned SIZE    = 4096,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_ready,
  input  logic [29:0] read_address,
  output logic [31:0] read_data,
  output logic        read_valid,
  input  logic        write_ready,
  input  logic [29:0] write_address,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_byte,
  output logic        write_valid,
  output logic        error
);

  localparam int unsigned AW    = $clog2(SIZE) - 2;
  localparam int unsigned WORDS = SIZE / 4;
  localparam logic [3:0]  LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;

  logic        r_is_write;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;

  logic [31:0] r_mem [WORDS];

  logic [31:0] r_read_data;
  logic        r_read_valid;
  logic        r_write_valid;
  logic        r_error;

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_op_write;
  logic [29:0] w_op_addr;
  logic [31:0] w_op_data;
  logic [3:0]  w_op_be;
  logic        w_oob;
  logic [AW-1:0] w_idx;
  logic        w_commit;
  logic [31:0] w_read_data_d;
  logic        w_read_valid_d;
  logic        w_write_valid_d;
  logic        w_error_d;

  assign w_accept = (r_state == IDLE) && (write_ready || read_ready);

  // With LATENCY=0 the RESP-entry edge is the accept edge, so the operation is
  // taken straight from the request inputs instead of the capture registers.
  always_comb begin
    if (r_state == IDLE) begin
      w_op_write = write_ready;
      w_op_addr  = write_ready ? write_address : read_address;
      w_op_data  = write_data;
      w_op_be    = write_byte;
    end else begin
      w_op_write = r_is_write;
      w_op_addr  = r_addr;
      w_op_data  = r_wdata;
      w_op_be    = r_be;
    end
  end

  assign w_oob = (w_op_addr >> AW) != '0;
  assign w_idx = w_op_addr[AW-1:0];

  always_comb begin
    w_next          = r_state;
    w_cnt_next      = r_cnt;
    w_read_data_d   = '0;
    w_read_valid_d  = 1'b0;
    w_write_valid_d = 1'b0;
    w_error_d       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY == 0) begin
            w_next = RESP;
          end else begin
            w_next     = WAIT;
            w_cnt_next = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_next = RESP;
        else               w_cnt_next = r_cnt - 4'd1;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    w_enter_resp = (w_next == RESP) && (r_state != RESP);
    if (w_enter_resp) begin
      w_read_valid_d  = ~w_op_write;
      w_write_valid_d = w_op_write;
      w_error_d       = w_oob;
      if (!w_op_write && !w_oob) w_read_data_d = r_mem[w_idx];
    end
  end

  assign w_commit = w_enter_resp && w_op_write && !w_oob && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
    end else if (w_accept) begin
      r_is_write <= write_ready;
      r_addr     <= write_ready ? write_address : read_address;
      r_wdata    <= write_data;
      r_be       <= write_byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_data   <= '0;
      r_read_valid  <= 1'b0;
      r_write_valid <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_read_data   <= w_read_data_d;
      r_read_valid  <= w_read_valid_d;
      r_write_valid <= w_write_valid_d;
      r_error       <= w_error_d;
    end
  end

  // RAM is deliberately not reset; the commit is gated by reset instead.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_op_be[i]) r_mem[w_idx][8*i +: 8] <= w_op_data[8*i +: 8];
      end
    end
  end

  assign read_data   = r_read_data;
  assign read_valid  = r_read_valid;
  assign write_valid = r_write_valid;
  assign error       = r_error;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance for the main directed
// vectors and a LATENCY=0 instance for zero-wait and back-to-back behaviour.
module tb_dmem_responder;

  localparam int L0 = 2;
  localparam int L1 = 0;

  typedef struct {
    logic        w;
    logic [31:0] d;
    logic        e;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   rc [2] = '{0, 0};
  exp_t q0 [$];
  exp_t q1 [$];

  logic        rr [2];
  logic [29:0] ra [2];
  logic        wr [2];
  logic [29:0] wa [2];
  logic [31:0] wd [2];
  logic [3:0]  wb [2];
  logic [31:0] rd [2];
  logic        rv [2];
  logic        wv [2];
  logic        er [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.SIZE(4096), .LATENCY(L0)) u_dut0 (
    .clk(clk), .reset(rst),
    .read_ready(rr[0]), .read_address(ra[0]), .read_data(rd[0]), .read_valid(rv[0]),
    .write_ready(wr[0]), .write_address(wa[0]), .write_data(wd[0]), .write_byte(wb[0]),
    .write_valid(wv[0]), .error(er[0])
  );

  dmem_responder #(.SIZE(4096), .LATENCY(L1)) u_dut1 (
    .clk(clk), .reset(rst),
    .read_ready(rr[1]), .read_address(ra[1]), .read_data(rd[1]), .read_valid(rv[1]),
    .write_ready(wr[1]), .write_address(wa[1]), .write_data(wd[1]), .write_byte(wb[1]),
    .write_valid(wv[1]), .error(er[1])
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic mon(input int u);
    exp_t e;
    if (rv[u] || wv[u]) begin
      if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
        tests++;
        fails++;
        $display("FAIL dut%0d unexpected_valid: rv=%b wv=%b required none (cycle %0d)",
                 u, rv[u], wv[u], cyc);
      end else begin
        if (u == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("dut%0d kind", u), {30'b0, rv[u], wv[u]}, e.w ? 32'h1 : 32'h2);
        chk($sformatf("dut%0d rdata", u), rd[u], e.w ? 32'h0 : e.d);
        chk($sformatf("dut%0d error", u), {31'b0, er[u]}, {31'b0, e.e});
        chk($sformatf("dut%0d latency", u), 32'(cyc), 32'(e.due));
        rc[u]++;
      end
    end else begin
      chk($sformatf("dut%0d idle_rdata", u), rd[u], 32'h0);
      chk($sformatf("dut%0d idle_error", u), {31'b0, er[u]}, 32'h0);
    end
  endtask

  always @(negedge clk) if (!rst) mon(0);
  always @(negedge clk) if (!rst) mon(1);

  task automatic push(input int u, input logic w, input logic [31:0] d, input logic e,
                      input int due);
    exp_t x;
    x.w = w; x.d = d; x.e = e; x.due = due;
    if (u == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic wait_resp(input int u, input int target);
    int k = 0;
    while (rc[u] < target && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (rc[u] < target) begin
      tests++;
      fails++;
      $display("FAIL dut%0d timeout: got %0d responses required %0d", u, rc[u], target);
      if (u == 0) q0.delete();
      else        q1.delete();
      rc[u] = target;
    end
  endtask

  // Issue one request on an idle DUT, wait for its completion, then drop the request.
  task automatic req(input int u, input logic w, input logic [29:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [31:0] exp, input logic e);
    int tgt;
    @(negedge clk);
    if (w) begin wr[u] = 1'b1; wa[u] = a; wd[u] = d; wb[u] = be; end
    else   begin rr[u] = 1'b1; ra[u] = a; end
    push(u, w, exp, e, cyc + 1 + (u == 0 ? L0 : L1));
    tgt = rc[u] + 1;
    wait_resp(u, tgt);
    wr[u] = 1'b0;
    rr[u] = 1'b0;
  endtask

  initial begin
    int base;
    int tgt;
    for (int u = 0; u < 2; u++) begin
      rr[u] = 0; ra[u] = '0; wr[u] = 0; wa[u] = '0; wd[u] = '0; wb[u] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("reset rdata", rd[u], 32'h0);
      chk("reset valids_error", {29'b0, rv[u], wv[u], er[u]}, 32'h0);
    end
    rst = 1'b0;

    req(0, 1, 30'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    req(0, 0, 30'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    req(0, 1, 30'h10, 32'h11223344, 4'h5, 32'h0, 0);
    req(0, 0, 30'h10, 32'h0, 4'h0, 32'hDE22BE44, 0);
    req(0, 1, 30'h10, 32'h00000000, 4'h0, 32'h0, 0);
    req(0, 0, 30'h10, 32'h0, 4'h0, 32'hDE22BE44, 0);

    // Simultaneous requests: write served first, read accepted LATENCY+2 later.
    @(negedge clk);
    wr[0] = 1; wa[0] = 30'h20; wd[0] = 32'hA5A5A5A5; wb[0] = 4'hF;
    rr[0] = 1; ra[0] = 30'h20;
    push(0, 1, 32'h0, 0, cyc + 1 + L0);
    push(0, 0, 32'hA5A5A5A5, 0, cyc + 1 + L0 + 4);
    tgt = rc[0] + 1;
    wait_resp(0, tgt);
    wr[0] = 0;
    wait_resp(0, tgt + 1);
    rr[0] = 0;

    req(0, 1, 30'h000, 32'h0BADF00D, 4'hF, 32'h0, 0);
    req(0, 1, 30'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    req(0, 0, 30'h400, 32'h0, 4'h0, 32'h0, 1);
    req(0, 0, 30'h000, 32'h0, 4'h0, 32'h0BADF00D, 0);
    req(0, 1, 30'h3FF, 32'h5A5A1234, 4'hF, 32'h0, 0);
    req(0, 0, 30'h3FF, 32'h0, 4'h0, 32'h5A5A1234, 0);

    // Reset during WAIT of a write: transaction aborted, RAM keeps preloaded 0.
    req(0, 1, 30'h30, 32'h00000000, 4'hF, 32'h0, 0);
    @(negedge clk);
    wr[0] = 1; wa[0] = 30'h30; wd[0] = 32'h12345678; wb[0] = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    wr[0] = 0;
    #1;
    chk("abort rdata", rd[0], 32'h0);
    chk("abort valids_error", {29'b0, rv[0], wv[0], er[0]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    req(0, 0, 30'h30, 32'h0, 4'h0, 32'h00000000, 0);

    // Zero-latency instance: preload, then a held read accepted every 2 cycles.
    req(1, 1, 30'h5, 32'hCAFEF00D, 4'hF, 32'h0, 0);
    req(1, 0, 30'h5, 32'h0, 4'h0, 32'hCAFEF00D, 0);
    @(negedge clk);
    rr[1] = 1; ra[1] = 30'h5;
    base = cyc;
    for (int i = 0; i < 3; i++) push(1, 0, 32'hCAFEF00D, 0, base + 1 + 2 * i);
    tgt = rc[1] + 3;
    wait_resp(1, tgt);
    rr[1] = 0;
    req(1, 0, 30'h7FF, 32'h0, 4'h0, 32'h0, 1);

    repeat (4) @(negedge clk);
    chk("dut0 queue_drained", 32'(q0.size()), 32'h0);
    chk("dut1 queue_drained", 32'(q1.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
